// File: rtl/multi_cycle_control_unit_pkg.sv
// rtl/multi_cycle_control_unit_pkg.sv - opcodes, FSM states and datapath select encodings
package multi_cycle_control_unit_pkg;

    localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD           = 7'b0000011;
    localparam logic [6:0] OP_STORE          = 7'b0100011;
    localparam logic [6:0] OP_BRANCH         = 7'b1100011;
    localparam logic [6:0] OP_JAL            = 7'b1101111;
    localparam logic [6:0] OP_JALR           = 7'b1100111;
    localparam logic [6:0] OP_ECALL          = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_FUNCT  = 2'd1;
    localparam logic [1:0] ALU_BRANCH = 2'd2;

    localparam logic [1:0] PCS_PC4    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_ALU    = 2'd2;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

endpackage

// File: rtl/multi_cycle_control_unit_mem_wait_counter.sv
// rtl/multi_cycle_control_unit_mem_wait_counter.sv - memory access wait counter shared by IF and MEM
module mem_wait_counter #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = $clog2(MEM_LATENCY + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // clear wins so the exit cycle of an access always leaves the counter at 0
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_W'(MEM_LATENCY - 1));

endmodule

// File: rtl/multi_cycle_control_unit.sv
// rtl/multi_cycle_control_unit.sv - multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB/HALT)
module multi_cycle_control_unit
    import multi_cycle_control_unit_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = $clog2(MEM_LATENCY + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       halt_cond,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       pc_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       is_ecall,
    output logic       is_halted
);

    state_e state_q;
    state_e state_d;
    logic   cnt_en;
    logic   cnt_clr;
    logic   cnt_last;

    mem_wait_counter #(
        .MEM_LATENCY(MEM_LATENCY),
        .CNT_W      (CNT_W)
    ) u_wait (
        .clk  (clk),
        .reset(reset),
        .en   (cnt_en),
        .clear(cnt_clr),
        .last (cnt_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        pc_to_reg  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        pc_source  = PCS_PC4;
        is_ecall   = 1'b0;
        is_halted  = 1'b0;

        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                cnt_en   = 1'b1;
                if (cnt_last) begin
                    ir_write = 1'b1;
                    cnt_clr  = 1'b1;
                    state_d  = S_ID;
                end
            end

            S_ID: begin
                // branch/JAL target PC+imm is parked in ALUOut for EX
                alu_src_b = SRCB_IMM;
                is_ecall  = (opcode == OP_ECALL);
                state_d   = S_EX;
            end

            S_EX: begin
                case (opcode)
                    OP_ARITHMETIC: begin
                        alu_src_a = 1'b1;
                        alu_op    = ALU_FUNCT;
                        state_d   = S_WB;
                    end
                    OP_ARITHMETIC_IMM: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALU_FUNCT;
                        state_d   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_IMM;
                        state_d   = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a = 1'b1;
                        alu_op    = ALU_BRANCH;
                        pc_write  = 1'b1;
                        pc_source = bcond ? PCS_ALUOUT : PCS_PC4;
                        state_d   = S_IF;
                    end
                    OP_JAL: begin
                        reg_write = 1'b1;
                        pc_to_reg = 1'b1;
                        pc_write  = 1'b1;
                        pc_source = PCS_ALUOUT;
                        state_d   = S_IF;
                    end
                    OP_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_IMM;
                        reg_write = 1'b1;
                        pc_to_reg = 1'b1;
                        pc_write  = 1'b1;
                        pc_source = PCS_ALU;
                        state_d   = S_IF;
                    end
                    OP_ECALL: begin
                        is_ecall = 1'b1;
                        if (halt_cond) begin
                            state_d = S_HALT;
                        end else begin
                            pc_write = 1'b1;
                            state_d  = S_IF;
                        end
                    end
                    default: begin
                        pc_write = 1'b1;
                        state_d  = S_IF;
                    end
                endcase
            end

            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (opcode == OP_LOAD);
                mem_write = (opcode == OP_STORE);
                cnt_en    = 1'b1;
                if (cnt_last) begin
                    cnt_clr = 1'b1;
                    if (opcode == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_IF;
                    end
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = (opcode == OP_LOAD);
                state_d    = S_IF;
            end

            S_HALT: begin
                is_halted = 1'b1;
            end

            default: begin
                state_d = S_IF;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb/tb_multi_cycle_control_unit.sv - self-checking bench for multi_cycle_control_unit
module tb_multi_cycle_control_unit;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       is_ecall;
        logic       is_halted;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        logic       bc;
        int         cycles;
        int         regw;
        logic [1:0] pcs;
    } vec_t;

    localparam logic [6:0] ARITH  = 7'b0110011;
    localparam logic [6:0] ARITHI = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] ECALL  = 7'b1110011;

    localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;

    logic       clk = 1'b0;
    logic       rst   [3];
    logic [6:0] opc   [3];
    logic       bcd   [3];
    logic       hcd   [3];
    ctl_t       outs  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pcw, iod, mrd, mwr, irw, m2r, rgw, p2r, sa, ise, ish;
        logic [1:0] sb, aop, pcs;
        multi_cycle_control_unit #(.MEM_LATENCY((g == 0) ? 1 : (g == 1) ? 3 : 4)) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .opcode    (opc[g]),
            .bcond     (bcd[g]),
            .halt_cond (hcd[g]),
            .pc_write  (pcw),
            .i_or_d    (iod),
            .mem_read  (mrd),
            .mem_write (mwr),
            .ir_write  (irw),
            .mem_to_reg(m2r),
            .reg_write (rgw),
            .pc_to_reg (p2r),
            .alu_src_a (sa),
            .alu_src_b (sb),
            .alu_op    (aop),
            .pc_source (pcs),
            .is_ecall  (ise),
            .is_halted (ish)
        );
        assign outs[g] = {pcw, iod, mrd, mwr, irw, m2r, rgw, p2r, sa, sb, aop, pcs, ise, ish};
    end

    function automatic int ml_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 4;
    endfunction

    // Expected controls for one cycle of an instruction, from the per-phase rules
    function automatic ctl_t exp_ctl(input int ph, input int ml, input int k,
                                     input logic [6:0] op, input logic bc, input logic hc);
        ctl_t c = '0;
        case (ph)
            P_IF: begin
                c.mem_read = 1'b1;
                c.ir_write = (k == ml - 1);
            end
            P_ID: begin
                c.alu_src_b = 2'd1;
                c.is_ecall  = (op == ECALL);
            end
            P_EX: begin
                if (op == ARITH) begin
                    c.alu_src_a = 1'b1; c.alu_op = 2'd1;
                end else if (op == ARITHI) begin
                    c.alu_src_a = 1'b1; c.alu_src_b = 2'd1; c.alu_op = 2'd1;
                end else if (op == LOAD || op == STORE) begin
                    c.alu_src_a = 1'b1; c.alu_src_b = 2'd1;
                end else if (op == BRANCH) begin
                    c.alu_src_a = 1'b1; c.alu_op = 2'd2; c.pc_write = 1'b1;
                    c.pc_source = bc ? 2'd1 : 2'd0;
                end else if (op == JAL) begin
                    c.reg_write = 1'b1; c.pc_to_reg = 1'b1; c.pc_write = 1'b1; c.pc_source = 2'd1;
                end else if (op == JALR) begin
                    c.alu_src_a = 1'b1; c.alu_src_b = 2'd1; c.reg_write = 1'b1;
                    c.pc_to_reg = 1'b1; c.pc_write = 1'b1; c.pc_source = 2'd2;
                end else if (op == ECALL) begin
                    c.is_ecall = 1'b1; c.pc_write = !hc;
                end else begin
                    c.pc_write = 1'b1;
                end
            end
            P_MEM: begin
                c.i_or_d    = 1'b1;
                c.mem_read  = (op == LOAD);
                c.mem_write = (op == STORE);
                c.pc_write  = (op == STORE) && (k == ml - 1);
            end
            P_WB: begin
                c.reg_write  = 1'b1;
                c.pc_write   = 1'b1;
                c.mem_to_reg = (op == LOAD);
            end
            default: c.is_halted = 1'b1;
        endcase
        return c;
    endfunction

    task automatic chk(input string name, input int d, input ctl_t got, input ctl_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h", name, d, got, want);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic step(input int d, input int ph, input int k, input string name);
        #1;
        chk(name, d, outs[d], exp_ctl(ph, ml_of(d), k, opc[d], bcd[d], hcd[d]));
        @(negedge clk);
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        #1;
        chk("reset_if", d, outs[d], exp_ctl(P_IF, ml_of(d), 0, opc[d], 1'b0, 1'b0));
        @(negedge clk);
        rst[d] = 1'b0;
    endtask

    task automatic run_instr(input int d, input logic [6:0] op, input logic bc, input logic hc,
                             output int cycles);
        int ml = ml_of(d);
        opc[d] = op; bcd[d] = bc; hcd[d] = hc;
        cycles = 0;
        for (int k = 0; k < ml; k++) begin step(d, P_IF, k, "fetch"); cycles++; end
        step(d, P_ID, 0, "decode"); cycles++;
        step(d, P_EX, 0, "execute"); cycles++;
        if (op == LOAD || op == STORE)
            for (int k = 0; k < ml; k++) begin step(d, P_MEM, k, "memory"); cycles++; end
        if (op == LOAD || op == ARITH || op == ARITHI) begin
            step(d, P_WB, 0, "writeback"); cycles++;
        end
        if (op == ECALL && hc) begin
            for (int k = 0; k < 10; k++) step(d, P_HALT, 0, "halted");
            do_reset(d);
        end
    endtask

    vec_t       vecs [10];
    logic [6:0] ops  [10];

    initial begin
        int cyc, regw, seen;
        logic [1:0] pcs;

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; opc[d] = '0; bcd[d] = 1'b0; hcd[d] = 1'b0;
        end

        // ML=1: cycles up to and including the PC write, rd writes, final pc_source
        vecs[0] = '{ARITH,       1'b0, 4, 1, 2'd0};
        vecs[1] = '{ARITHI,      1'b0, 4, 1, 2'd0};
        vecs[2] = '{LOAD,        1'b0, 5, 1, 2'd0};
        vecs[3] = '{STORE,       1'b0, 4, 0, 2'd0};
        vecs[4] = '{BRANCH,      1'b1, 3, 0, 2'd1};
        vecs[5] = '{BRANCH,      1'b0, 3, 0, 2'd0};
        vecs[6] = '{JAL,         1'b0, 3, 1, 2'd1};
        vecs[7] = '{JALR,        1'b0, 3, 1, 2'd2};
        vecs[8] = '{ECALL,       1'b0, 3, 0, 2'd0};
        vecs[9] = '{7'b0001111,  1'b0, 3, 0, 2'd0};

        ops = '{ARITH, ARITHI, LOAD, STORE, BRANCH, JAL, JALR, ECALL, 7'b0001111, 7'b1111111};

        @(negedge clk);
        for (int d = 0; d < 3; d++) do_reset(d);

        for (int v = 0; v < 10; v++) begin
            do_reset(0);
            opc[0] = vecs[v].op; bcd[0] = vecs[v].bc; hcd[0] = 1'b0;
            cyc = 0; regw = 0; seen = 0; pcs = 2'd3;
            for (int t = 0; t < 20 && seen == 0; t++) begin
                #1;
                cyc++;
                if (outs[0].reg_write) regw++;
                if (outs[0].pc_write) begin seen = 1; pcs = outs[0].pc_source; end
                @(negedge clk);
            end
            chk_int("vec_cycles", cyc, seen ? vecs[v].cycles : -1);
            chk_int("vec_regw", regw, vecs[v].regw);
            chk_int("vec_pcsrc", int'(pcs), int'(vecs[v].pcs));
        end

        do_reset(1);
        run_instr(1, LOAD, 1'b0, 1'b0, cyc);
        chk_int("load_ml3_cycles", cyc, 9);
        do_reset(0);
        run_instr(0, ARITH, 1'b0, 1'b0, cyc);
        chk_int("add_ml1_cycles", cyc, 4);
        run_instr(0, ECALL, 1'b0, 1'b1, cyc);
        run_instr(0, ECALL, 1'b0, 1'b0, cyc);
        chk_int("ecall_cont_cycles", cyc, 3);

        // reset asserted mid-MEM of a STORE at ML=4
        do_reset(2);
        opc[2] = STORE; bcd[2] = 1'b0; hcd[2] = 1'b0;
        for (int k = 0; k < 4; k++) step(2, P_IF, k, "st_fetch");
        step(2, P_ID, 0, "st_decode");
        step(2, P_EX, 0, "st_execute");
        step(2, P_MEM, 0, "st_mem0");
        step(2, P_MEM, 1, "st_mem1");
        #1;
        chk("st_mem2", 2, outs[2], exp_ctl(P_MEM, 4, 2, STORE, 1'b0, 1'b0));
        #2;
        rst[2] = 1'b1;
        #1;
        chk("async_reset", 2, outs[2], exp_ctl(P_IF, 4, 0, STORE, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        chk("reset_held", 2, outs[2], exp_ctl(P_IF, 4, 0, STORE, 1'b0, 1'b0));
        @(negedge clk);
        rst[2] = 1'b0;
        run_instr(2, STORE, 1'b0, 1'b0, cyc);
        chk_int("store_ml4_cycles", cyc, 10);

        for (int d = 0; d < 3; d++) begin
            do_reset(d);
            for (int i = 0; i < 25; i++) begin
                logic [6:0] op;
                op = ops[$urandom_range(0, 9)];
                run_instr(d, op, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), cyc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- Successor to the single-cycle RV32I control decoder: a multi-cycle FSM that sequences one instruction over IF/ID/EX/MEM/WB.
- Drives a shared-ALU, shared-memory datapath.
- Memory access latency is parametrised through an internal wait counter.
- Handles ECALL halt and exposes a sticky halted flag to the testbench.

Parameters:
- MEM_LATENCY, 1, cycles per memory access (>=1); mem_read/mem_write held for all of them.
- CNT_W, $clog2(MEM_LATENCY+1), wait-counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state IF and counter 0.
- opcode  in  7  IR[6:0]; sampled in ID/EX/MEM/WB only, ignored in IF.
- bcond  in  1  branch condition from ALU, valid in EX of BRANCH.
- halt_cond  in  1  ECALL halt test (x17==10), valid in EX of ECALL.
- pc_write  out  1  PC register load enable.
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- mem_to_reg  out  1  rd data select: 1 MDR, 0 ALUOut.
- reg_write  out  1  register file write enable.
- pc_to_reg  out  1  rd data = PC+4 (overrides mem_to_reg).
- alu_src_a  out  1  0 PC, 1 rs1.
- alu_src_b  out  2  0 rs2, 1 imm, 2 const 4.
- alu_op  out  2  0 ADD, 1 FUNCT (funct3/7 decode), 2 BRANCH compare.
- pc_source  out  2  0 PC+4 adder, 1 ALUOut register, 2 live ALU result.
- is_ecall  out  1  high in ID and EX of ECALL.
- is_halted  out  1  high in HALT.

Behaviour:
- Outputs are combinational from state, opcode, counter and bcond; every output not listed for a state is 0.
- Reset: state=IF, cnt=0. While reset is asserted, outputs show IF decode: mem_read=1, i_or_d=0, ir_write=(MEM_LATENCY==1); all others 0. A reset mid-instruction abandons it with no further writes.
- IF:
  - mem_read=1, i_or_d=0; cnt increments each cycle.
  - When cnt==MEM_LATENCY-1: ir_write=1, cnt<=0, next ID.
- ID:
  - ALU computes PC+imm into ALUOut: alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - is_ecall=1 if opcode==ECALL. Next EX.
- EX, by opcode:
  - ARITHMETIC: a=1, b=0, alu_op=FUNCT; next WB.
  - ARITHMETIC_IMM: a=1, b=1, alu_op=FUNCT; next WB.
  - LOAD/STORE: a=1, b=1, ADD; next MEM.
  - BRANCH: a=1, b=0, alu_op=BRANCH, pc_write=1; pc_source=bcond?1:0; next IF.
  - JAL: reg_write=1, pc_to_reg=1, pc_write=1, pc_source=1; next IF.
  - JALR: a=1, b=1, ADD, reg_write=1, pc_to_reg=1, pc_write=1, pc_source=2; next IF.
  - ECALL: is_ecall=1. halt_cond=1 -> HALT with no PC write; else pc_write=1, pc_source=0, next IF.
  - Any other opcode: NOP, pc_write=1, pc_source=0; next IF.
- MEM:
  - i_or_d=1; mem_read=1 for LOAD, mem_write=1 for STORE; cnt counts as in IF.
  - At cnt==MEM_LATENCY-1:
    - LOAD: next WB.
    - STORE: pc_write=1, pc_source=0; next IF.
  - cnt<=0 on exit.
- WB:
  - reg_write=1, pc_write=1, pc_source=0; mem_to_reg=1 for LOAD else 0. Next IF.
- HALT: terminal, is_halted=1, all write enables 0; exit only by reset.
- Same-edge writes (rd and PC in JAL/JALR/WB) both use pre-edge PC values. The datapath guarantees this.
- CPI: ALU 4, branch/jump/ecall 3, load 3+2*MEM_LATENCY, store 2+2*MEM_LATENCY (all at MEM_LATENCY=1 baseline plus extra fetch/mem waits).

Decomposition:
- Package: opcode constants (ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JAL, JALR, ECALL), state encoding (IF, ID, EX, MEM, WB, HALT), and alu_op/pc_source/alu_src_b encodings.
- Sub-module mem_wait_counter: inputs clk, reset, en, clear; output last = (cnt==MEM_LATENCY-1). Shared by IF and MEM.

Test Plan:
- Reset, MEM_LATENCY=1, opcode ADD (0110011) -> states IF,ID,EX,WB; reg_write=1 only in WB; pc_write=1 only in WB with pc_source=0; 4 cycles.
- MEM_LATENCY=3, LOAD -> mem_read high 3 cycles in IF (ir_write only on 3rd) and 3 cycles in MEM with i_or_d=1; WB mem_to_reg=1; 9 cycles total.
- BRANCH with bcond=1 -> EX pc_write=1, pc_source=1. With bcond=0 -> pc_source=0. No reg_write in either case.
- JALR -> EX: reg_write=1, pc_to_reg=1, pc_source=2, alu_src_a=1, alu_src_b=1. Next state IF.
- ECALL with halt_cond=1 -> is_ecall=1 in ID/EX, then is_halted=1 held for 10 cycles with no write enables. With halt_cond=0 -> PC+4, continues.
- Reset asserted in MEM of a STORE with MEM_LATENCY=4 -> mem_write drops immediately (asynchronously); state IF, cnt=0; no pc_write occurs.
